// File: rtl/vga_pkg.sv
// Shared VGA types and helpers.
//   rgb332_t           : packed RGB332 pixel {r[2:0], g[2:0], b[1:0]}
//   RGB332_TRANSPARENT : default colour key
//   rgb332_to_rgb888() : expands a pixel to 24-bit colour by replicating
//                        each field's LSB into the low bits
package vga_pkg;
  typedef logic [7:0] rgb332_t;

  localparam rgb332_t RGB332_TRANSPARENT = 8'hFF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic rgb888_t rgb332_to_rgb888(input rgb332_t c);
    rgb888_t o;
    o.r = {c[7:5], {5{c[5]}}};
    o.g = {c[4:2], {5{c[2]}}};
    o.b = {c[1:0], {6{c[0]}}};
    return o;
  endfunction
endpackage

// File: rtl/layer_compositor_if.sv
// Pixel bus from the object drawers into the compositor.
//   layerRGB      : packed RGB332 per layer, layer i at [8*i+7:8*i]
//   layerDrawReq  : per-layer draw request
//   layerEnable   : per-layer static enable
//   layerBlink    : per-layer blink select
//   backGroundRGB : background colour
//   startOfFrame  : one-cycle pulse on the first pixel of a frame
// master = drawer side (drives), slave = compositor side (samples).
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 6
);
  logic [8*NUM_LAYERS-1:0] layerRGB;
  logic [NUM_LAYERS-1:0]   layerDrawReq;
  logic [NUM_LAYERS-1:0]   layerEnable;
  logic [NUM_LAYERS-1:0]   layerBlink;
  logic [7:0]              backGroundRGB;
  logic                    startOfFrame;

  modport master (output layerRGB, layerDrawReq, layerEnable, layerBlink,
                         backGroundRGB, startOfFrame);
  modport slave  (input  layerRGB, layerDrawReq, layerEnable, layerBlink,
                         backGroundRGB, startOfFrame);
endinterface

// File: rtl/layer_priority_enc.sv
// Combinational priority encoder: lowest set bit of vis wins.
//   vis   : per-layer visibility
//   valid : any layer visible
//   idx   : winning index, NUM_LAYERS when nothing is visible
module layer_priority_enc #(
  parameter int NUM_LAYERS = 6,
  parameter int IW         = $clog2(NUM_LAYERS+1)
) (
  input  logic [NUM_LAYERS-1:0] vis,
  output logic                  valid,
  output logic [IW-1:0]         idx
);
  always_comb begin
    valid = 1'b0;
    idx   = IW'(NUM_LAYERS);
    // Walk from the lowest priority up so layer 0 overrides last.
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (vis[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor: picks the highest-priority visible layer (else
// background), expands RGB332 to 24-bit, applies per-layer enable, colour
// key and frame-synchronous blink, and reports per-frame collisions against
// COLLIDE_LAYER.
//   clk, resetN      : pixel clock, async active-low reset
//   lay              : drawer pixel bus (slave side)
//   redOut/greenOut/blueOut : colour, 2 clk after inputs
//   topLayer         : winning index (NUM_LAYERS = background), aligned with colour
//   collisionMask    : layers that overlapped COLLIDE_LAYER in the last frame
//   collisionValid   : one-cycle pulse after each startOfFrame
module layer_compositor
  import vga_pkg::*;
#(
  parameter int      NUM_LAYERS    = 6,
  parameter rgb332_t TRANSPARENT   = RGB332_TRANSPARENT,
  parameter int      BLINK_FRAMES  = 16,
  parameter int      COLLIDE_LAYER = 0,
  localparam int     TW            = $clog2(NUM_LAYERS+1)
) (
  input  logic                  clk,
  input  logic                  resetN,
  layer_compositor_if.slave     lay,
  output logic [7:0]            redOut,
  output logic [7:0]            greenOut,
  output logic [7:0]            blueOut,
  output logic [TW-1:0]         topLayer,
  output logic [NUM_LAYERS-1:0] collisionMask,
  output logic                  collisionValid
);
  logic [NUM_LAYERS-1:0] vis, hits;
  rgb332_t               rgb_arr [NUM_LAYERS];
  logic                  enc_valid;
  logic [TW-1:0]         enc_idx;
  rgb888_t               exp_c;

  rgb332_t               win_rgb_q, win_rgb_d;
  logic [TW-1:0]         win_idx_q, win_idx_d;
  rgb888_t               col_q, col_d;
  logic [TW-1:0]         top_q, top_d;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_LAYERS-1:0] acc_q, acc_d, mask_q, mask_d;
  logic                  cvalid_q, cvalid_d;

  always_comb begin
    vis = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      rgb_arr[i] = lay.layerRGB[8*i +: 8];
      vis[i] = lay.layerDrawReq[i] & lay.layerEnable[i] &
               (lay.layerRGB[8*i +: 8] != TRANSPARENT) &
               (~lay.layerBlink[i] | blink_phase_q);
    end
  end

  layer_priority_enc #(.NUM_LAYERS(NUM_LAYERS), .IW(TW)) u_enc (
    .vis   (vis),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign exp_c = rgb332_to_rgb888(win_rgb_q);

  always_comb begin
    // Colour pipeline: select, then expand.
    win_rgb_d = enc_valid ? rgb_arr[enc_idx] : lay.backGroundRGB;
    win_idx_d = enc_idx;
    col_d     = exp_c;
    top_d     = win_idx_q;

    // Blink runs off the raw frame pulse, so the pixel sharing startOfFrame
    // still sees the old phase.
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (lay.startOfFrame) begin
      if (blink_cnt_q == 8'(BLINK_FRAMES-1)) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end

    // Collision: the reference layer never collides with itself.
    hits                = vis[COLLIDE_LAYER] ? vis : '0;
    hits[COLLIDE_LAYER] = 1'b0;
    acc_d    = acc_q | hits;
    mask_d   = mask_q;
    cvalid_d = lay.startOfFrame;
    if (lay.startOfFrame) begin
      mask_d = acc_q | hits;   // this pixel closes the ending frame
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      win_rgb_q     <= '0;
      win_idx_q     <= TW'(NUM_LAYERS);
      col_q         <= '0;
      top_q         <= TW'(NUM_LAYERS);
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      acc_q         <= '0;
      mask_q        <= '0;
      cvalid_q      <= 1'b0;
    end else begin
      win_rgb_q     <= win_rgb_d;
      win_idx_q     <= win_idx_d;
      col_q         <= col_d;
      top_q         <= top_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      acc_q         <= acc_d;
      mask_q        <= mask_d;
      cvalid_q      <= cvalid_d;
    end
  end

  assign redOut         = col_q.r;
  assign greenOut       = col_q.g;
  assign blueOut        = col_q.b;
  assign topLayer       = top_q;
  assign collisionMask  = mask_q;
  assign collisionValid = cvalid_q;
endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;
  localparam int NL = 6;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] redOut, greenOut, blueOut;
  logic [2:0] topLayer;
  logic [NL-1:0] collisionMask;
  logic       collisionValid;
  int         checks = 0;
  int         failures = 0;

  layer_compositor_if #(.NUM_LAYERS(NL)) lay();

  layer_compositor #(
    .NUM_LAYERS(NL), .TRANSPARENT(8'hFF), .BLINK_FRAMES(2), .COLLIDE_LAYER(0)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .lay            (lay),
    .redOut         (redOut),
    .greenOut       (greenOut),
    .blueOut        (blueOut),
    .topLayer       (topLayer),
    .collisionMask  (collisionMask),
    .collisionValid (collisionValid)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rgb(input int i, input logic [7:0] v);
    lay.layerRGB[8*i +: 8] = v;
  endtask

  task automatic chk_col(input string tag, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic [2:0] t);
    chk({tag, ".red"},   {24'd0, redOut},   {24'd0, r});
    chk({tag, ".green"}, {24'd0, greenOut}, {24'd0, g});
    chk({tag, ".blue"},  {24'd0, blueOut},  {24'd0, b});
    chk({tag, ".top"},   {29'd0, topLayer}, {29'd0, t});
  endtask

  // One-cycle startOfFrame; mask/valid checked in the cycle after the pulse.
  task automatic do_sof(input string tag, input logic [NL-1:0] exp_mask);
    lay.startOfFrame = 1'b1;
    step();
    lay.startOfFrame = 1'b0;
    chk({tag, ".valid"}, {31'd0, collisionValid}, 32'd1);
    chk({tag, ".mask"},  {26'd0, collisionMask},  {26'd0, exp_mask});
    step();
    chk({tag, ".valid_drop"}, {31'd0, collisionValid}, 32'd0);
  endtask

  initial begin
    resetN            = 1'b0;
    lay.layerRGB      = '0;
    lay.layerDrawReq  = '0;
    lay.layerEnable   = '1;
    lay.layerBlink    = '0;
    lay.backGroundRGB = 8'h00;
    lay.startOfFrame  = 1'b0;
    step(3);
    chk_col("reset", 8'h00, 8'h00, 8'h00, 3'd6);
    chk("reset.mask",  {26'd0, collisionMask},  32'd0);
    chk("reset.valid", {31'd0, collisionValid}, 32'd0);
    resetN = 1'b1;
    step(2);

    // Priority: layers 0 and 2 request; layer 0 wins after exactly 2 clk.
    set_rgb(0, 8'hE0);
    set_rgb(2, 8'h1C);
    lay.layerDrawReq = 6'b000101;
    step();
    chk("latency.top_1clk", {29'd0, topLayer}, 32'd6);
    step();
    chk_col("prio0", 8'hFF, 8'h00, 8'h00, 3'd0);
    lay.layerDrawReq = 6'b000100;
    step(2);
    chk_col("prio2", 8'h00, 8'hFF, 8'h00, 3'd2);
    // Layers 0/2 overlapped for two pixels this frame.
    do_sof("sof_prio", 6'b000100);

    // Colour key: layer 0 transparent, layer 1 wins; no collision recorded.
    set_rgb(0, 8'hFF);
    set_rgb(1, 8'h03);
    lay.layerDrawReq = 6'b000011;
    step(2);
    chk_col("key", 8'h00, 8'h00, 8'hFF, 3'd1);
    do_sof("sof_key", 6'b000000);

    // Background only.
    lay.layerDrawReq  = '0;
    lay.backGroundRGB = 8'h49;
    step(2);
    chk_col("bg", 8'h40, 8'h40, 8'h7F, 3'd6);
    lay.backGroundRGB = 8'h00;

    // Layer disable hides a requesting layer.
    set_rgb(4, 8'h1C);
    lay.layerDrawReq = 6'b010000;
    lay.layerEnable  = 6'b101111;
    step(2);
    chk("disable.top", {29'd0, topLayer}, 32'd6);
    lay.layerEnable  = '1;
    lay.layerDrawReq = '0;
    step(2);
    do_sof("sof_pre_col", 6'b000000);

    // Layers 0 and 3 overlap for 5 pixels.
    set_rgb(0, 8'h10);
    set_rgb(3, 8'h20);
    lay.layerDrawReq = 6'b001001;
    step(5);
    lay.layerDrawReq = '0;
    step(3);
    do_sof("sof_col", 6'b001000);
    step(4);
    do_sof("sof_nocol", 6'b000000);

    // Overlap only on the startOfFrame pixel counts in the ending frame.
    lay.layerDrawReq = 6'b001001;
    do_sof("sof_edge", 6'b001000);
    // Overlap continues into the new frame, then reset mid-frame.
    step(3);
    resetN = 1'b0;
    step();
    chk("midreset.mask",  {26'd0, collisionMask},  32'd0);
    chk("midreset.valid", {31'd0, collisionValid}, 32'd0);
    chk("midreset.top",   {29'd0, topLayer},       32'd6);
    lay.layerDrawReq = '0;
    resetN = 1'b1;
    step(3);
    do_sof("sof_after_reset", 6'b000000);

    // Blink: fresh reset, BLINK_FRAMES=2, layer 1 blinks.
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    set_rgb(1, 8'h03);
    lay.layerBlink   = 6'b000010;
    lay.layerDrawReq = 6'b000010;
    step(2);
    chk("blink.f0", {29'd0, topLayer}, 32'd1);
    do_sof("sof_b1", 6'b000000);
    step(2);
    chk("blink.f1", {29'd0, topLayer}, 32'd1);
    do_sof("sof_b2", 6'b000000);
    step(2);
    chk_col("blink.f2", 8'h00, 8'h00, 8'h00, 3'd6);
    do_sof("sof_b3", 6'b000000);
    step(2);
    chk("blink.f3", {29'd0, topLayer}, 32'd6);
    do_sof("sof_b4", 6'b000000);
    step(2);
    chk_col("blink.f4", 8'h00, 8'h00, 8'hFF, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
